msx_slot_bus_initiator: RTL and testbench

Converts asynchronous MSX cartridge-slot Z80 strobes into single transactions on the internal cartridge bus (memreq/ioreq/address/write/valid/ready/wdata). It sits between the slot pins and the internal devices, such as the dual OPLL responder. It is the initiator side of that bus. It also returns read data to the slot and can stretch Z80 cycles via /WAIT.

---
 rtl/msx_slot_bus_pkg.sv | 16 +
 rtl/msx_strobe_sync.sv | 28 ++
 rtl/msx_slot_bus_initiator.sv | 163 ++++++++++++++++
 tb/tb_msx_slot_bus_initiator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/msx_slot_bus_pkg.sv
// msx_slot_bus_pkg: shared types and constants for the MSX slot bus initiator.
//   state_t   - initiator FSM states (IDLE, REQ, HOLD)
//   OPEN_BUS  - value returned on reads when no responder drives the bus
//   TMO_CNT_W - width of the REQ-state timeout counter
package msx_slot_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [7:0] OPEN_BUS  = 8'hFF;
   localparam int         TMO_CNT_W = 8;

endpackage

// File: rtl/msx_strobe_sync.sv
// msx_strobe_sync: multi-bit flip-flop chain synchronizer for active-low strobes.
//   i_clk   - sampling clock
//   i_rst   - asynchronous active-high reset; every stage resets to 1 (strobe inactive)
//   i_async - asynchronous strobe inputs
//   o_sync  - strobes after SYNC_STAGES flip-flops
module msx_strobe_sync #(
   parameter int unsigned WIDTH       = 6,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/msx_slot_bus_initiator.sv
// msx_slot_bus_initiator: turns asynchronous Z80 slot strobes into single transactions on
// the internal cartridge bus and returns read data to the slot.
//   clk, reset          - system clock, asynchronous active-high reset
//   slot_a, slot_d_in   - Z80 address / write data, sampled at the detect cycle
//   slot_*_n strobes    - sltsl, mreq, iorq, m1, rd, wr (synchronized internally)
//   slot_d_out/_oe      - read data back to the Z80 and its output enable
//   slot_wait_n         - Z80 wait request (only driven when MSX_SLOT_WAIT_EN is defined)
//   bus_*               - initiator side of the cartridge bus (valid/ready handshake)
//   timeout_flag        - sticky abort indicator, cleared by reset only
// Optional feature macro: MSX_SLOT_WAIT_EN (stretch Z80 cycles while a request is open).
module msx_slot_bus_initiator
   import msx_slot_bus_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] slot_a,
   input  logic [7:0]  slot_d_in,
   output logic [7:0]  slot_d_out,
   output logic        slot_d_oe,
   input  logic        slot_sltsl_n,
   input  logic        slot_mreq_n,
   input  logic        slot_iorq_n,
   input  logic        slot_m1_n,
   input  logic        slot_rd_n,
   input  logic        slot_wr_n,
   output logic        slot_wait_n,
   output logic        bus_memreq,
   output logic        bus_ioreq,
   output logic [15:0] bus_address,
   output logic        bus_write,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic [7:0]  bus_wdata,
   input  logic [7:0]  bus_rdata,
   input  logic        bus_rdata_en,
   output logic        timeout_flag
);

   localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [5:0] w_raw;
   logic [5:0] w_sync;
   logic       w_sltsl_n, w_mreq_n, w_iorq_n, w_m1_n, w_rd_n, w_wr_n;
   logic       w_one_strobe, w_mem, w_io, w_active, w_detect;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_warm;
   logic                   r_active_prev;
   logic                   r_valid, r_memreq, r_ioreq, r_write;
   logic [15:0]            r_addr;
   logic [7:0]             r_wdata;
   logic [7:0]             r_rdata;
   logic                   r_rd_ok;
   logic                   r_timeout;
   logic [TMO_CNT_W-1:0]   r_cnt;

   assign w_raw = {slot_sltsl_n, slot_mreq_n, slot_iorq_n, slot_m1_n, slot_rd_n, slot_wr_n};

   msx_strobe_sync #(
      .WIDTH       (6),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_strobe_sync (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_async (w_raw),
      .o_sync  (w_sync)
   );

   assign {w_sltsl_n, w_mreq_n, w_iorq_n, w_m1_n, w_rd_n, w_wr_n} = w_sync;

   // Exactly one of rd/wr active; mreq+iorq together or iorq with m1 (INTA) never qualify.
   assign w_one_strobe = w_rd_n ^ w_wr_n;
   assign w_mem        = !w_mreq_n & !w_sltsl_n & w_iorq_n & w_one_strobe;
   assign w_io         = !w_iorq_n & w_m1_n & w_mreq_n & w_one_strobe;
   assign w_active     = w_mem | w_io;

   // r_warm fills with ones once the synchronizer holds real pin values. Until then the
   // previous-active term is forced high, so a strobe held across reset is not seen as an edge.
   assign w_detect = r_warm[SYNC_STAGES-1] & w_active & !r_active_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_warm        <= '0;
         r_active_prev <= 1'b1;
         r_valid       <= 1'b0;
         r_memreq      <= 1'b0;
         r_ioreq       <= 1'b0;
         r_write       <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_rdata       <= OPEN_BUS;
         r_rd_ok       <= 1'b0;
         r_timeout     <= 1'b0;
         r_cnt         <= '0;
      end else begin
         r_warm        <= {r_warm[SYNC_STAGES-2:0], 1'b1};
         r_active_prev <= r_warm[SYNC_STAGES-1] ? w_active : 1'b1;
         unique case (r_state)
            IDLE: begin
               r_rd_ok <= 1'b0;
               if (w_detect) begin
                  r_memreq <= w_mem;
                  r_ioreq  <= w_io;
                  r_addr   <= slot_a;
                  r_write  <= !w_wr_n;
                  r_wdata  <= slot_d_in;
                  r_valid  <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= REQ;
               end
            end
            REQ: begin
               if (r_valid && bus_ready) begin
                  r_valid <= 1'b0;
                  if (!r_write) begin
                     r_rdata <= bus_rdata_en ? bus_rdata : OPEN_BUS;
                     r_rd_ok <= 1'b1;
                  end
                  r_state <= HOLD;
               end else if (r_cnt == TMO_LAST) begin
                  r_valid   <= 1'b0;
                  r_timeout <= 1'b1;
                  if (!r_write) begin
                     r_rdata <= OPEN_BUS;
                     r_rd_ok <= 1'b1;
                  end
                  r_state <= HOLD;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (!w_active) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus_memreq   = r_memreq;
   assign bus_ioreq    = r_ioreq;
   assign bus_address  = r_addr;
   assign bus_write    = r_write;
   assign bus_valid    = r_valid;
   assign bus_wdata    = r_wdata;
   assign timeout_flag = r_timeout;
   assign slot_d_out   = r_rdata;
   // Raw rd_n so the driver lets go as soon as the Z80 ends its read.
   assign slot_d_oe    = !slot_rd_n & (r_state == HOLD) & r_rd_ok;

`ifdef MSX_SLOT_WAIT_EN
   assign slot_wait_n = !((r_state == REQ) | ((r_state == IDLE) & w_detect));
`else
   assign slot_wait_n = 1'b1;
`endif

endmodule

// File: tb/tb_msx_slot_bus_initiator.sv
// tb_msx_slot_bus_initiator: directed and randomized slot accesses checked against a
// transaction-level expectation (which access qualifies, how long valid lasts, what the
// Z80 reads back, sticky timeout).
module tb_msx_slot_bus_initiator;

   localparam int SYNC = 2;
   localparam int TMO  = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] slot_a = '0;
   logic [7:0]  slot_d_in = '0;
   logic [7:0]  slot_d_out;
   logic        slot_d_oe;
   logic        slot_sltsl_n = 1'b1;
   logic        slot_mreq_n = 1'b1;
   logic        slot_iorq_n = 1'b1;
   logic        slot_m1_n = 1'b1;
   logic        slot_rd_n = 1'b1;
   logic        slot_wr_n = 1'b1;
   logic        slot_wait_n;
   logic        bus_memreq, bus_ioreq, bus_write, bus_valid;
   logic [15:0] bus_address;
   logic [7:0]  bus_wdata;
   logic        bus_ready = 1'b0;
   logic [7:0]  bus_rdata = '0;
   logic        bus_rdata_en = 1'b0;
   logic        timeout_flag;

   always #5 clk = ~clk;

   msx_slot_bus_initiator #(
      .SYNC_STAGES    (SYNC),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .slot_a       (slot_a),
      .slot_d_in    (slot_d_in),
      .slot_d_out   (slot_d_out),
      .slot_d_oe    (slot_d_oe),
      .slot_sltsl_n (slot_sltsl_n),
      .slot_mreq_n  (slot_mreq_n),
      .slot_iorq_n  (slot_iorq_n),
      .slot_m1_n    (slot_m1_n),
      .slot_rd_n    (slot_rd_n),
      .slot_wr_n    (slot_wr_n),
      .slot_wait_n  (slot_wait_n),
      .bus_memreq   (bus_memreq),
      .bus_ioreq    (bus_ioreq),
      .bus_address  (bus_address),
      .bus_write    (bus_write),
      .bus_valid    (bus_valid),
      .bus_ready    (bus_ready),
      .bus_wdata    (bus_wdata),
      .bus_rdata    (bus_rdata),
      .bus_rdata_en (bus_rdata_en),
      .timeout_flag (timeout_flag)
   );

   int         n_pass = 0;
   int         n_total = 0;
   logic [7:0] m_dout = 8'hFF;   // byte the Z80 should read back
   logic       m_tmo = 1'b0;     // sticky timeout expectation

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic idle_pins();
      slot_sltsl_n = 1'b1;
      slot_mreq_n  = 1'b1;
      slot_iorq_n  = 1'b1;
      slot_m1_n    = 1'b1;
      slot_rd_n    = 1'b1;
      slot_wr_n    = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".valid"}, bus_valid, 0);
      check({tag, ".busreq"}, {bus_memreq, bus_ioreq, bus_write}, 0);
      check({tag, ".addr"}, bus_address, 0);
      check({tag, ".wdata"}, bus_wdata, 0);
      check({tag, ".dout"}, slot_d_out, 8'hFF);
      check({tag, ".oe"}, slot_d_oe, 0);
      check({tag, ".wait"}, slot_wait_n, 1);
      check({tag, ".tmo"}, timeout_flag, 0);
   endtask

   // One Z80 access with the given pin levels; responder answers after `delay` valid
   // cycles (never if delay >= TMO). Strobe is held for a while after the bus settles.
   task automatic run_access(input string tag, input logic sl, input logic mr, input logic io,
                             input logic m1, input bit rd, input bit wr, input logic [15:0] a,
                             input logic [7:0] d, input int delay, input logic [7:0] rdata,
                             input bit rden);
      bit   exp_mem, exp_io, txn;
      int   nvalid, nrise, lat, exp_n;
      logic prev_v;
      exp_mem = !mr && !sl && io && (rd != wr);
      exp_io  = !io && m1 && mr && (rd != wr);
      txn     = exp_mem || exp_io;
      exp_n   = (delay < TMO) ? delay + 1 : TMO;
      nvalid  = 0;
      nrise   = 0;
      lat     = 0;
      prev_v  = 1'b0;
      @(negedge clk);
      slot_a       = a;
      slot_d_in    = d;
      slot_sltsl_n = sl;
      slot_mreq_n  = mr;
      slot_iorq_n  = io;
      slot_m1_n    = m1;
      slot_rd_n    = !rd;
      slot_wr_n    = !wr;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         bus_ready    = 1'b0;
         bus_rdata_en = 1'b0;
         if (bus_valid) begin
            if (!prev_v) begin
               nrise++;
               if (nrise == 1) lat = c;
            end
            nvalid++;
            check({tag, ".fields"}, {bus_memreq, bus_ioreq, bus_address, bus_write, bus_wdata},
                  {exp_mem, exp_io, a, wr, d});
`ifdef MSX_SLOT_WAIT_EN
            check({tag, ".wait_req"}, slot_wait_n, 0);
`else
            check({tag, ".wait_req"}, slot_wait_n, 1);
`endif
            if (nvalid == delay + 1) begin
               bus_ready    = 1'b1;
               bus_rdata    = rdata;
               bus_rdata_en = rden;
            end
         end
         prev_v = bus_valid;
      end
      check({tag, ".ntxn"}, nrise, txn ? 1 : 0);
      if (txn) begin
         check({tag, ".latency"}, lat, SYNC + 1);
         check({tag, ".vcycles"}, nvalid, exp_n);
         if (delay >= TMO) m_tmo = 1'b1;
         if (rd) m_dout = (delay >= TMO || !rden) ? 8'hFF : rdata;
         check({tag, ".oe_hold"}, slot_d_oe, rd);
      end else begin
         check({tag, ".oe_none"}, slot_d_oe, 0);
      end
      check({tag, ".dout"}, slot_d_out, m_dout);
      check({tag, ".tmo"}, timeout_flag, m_tmo);
      check({tag, ".wait_hold"}, slot_wait_n, 1);
      @(negedge clk);
      idle_pins();
      #1;
      check({tag, ".oe_rel"}, slot_d_oe, 0);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int nv;
      bit seen;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      repeat (3) @(negedge clk);

      //         tag       sl mr io m1 rd wr addr      data   dly rdata  en
      run_access("io_wr",   1, 1, 0, 1, 0, 1, 16'h007C, 8'h20, 0, 8'h00, 0);
      run_access("mem_wr",  0, 0, 1, 1, 0, 1, 16'h7FF5, 8'h07, 0, 8'h00, 0);
      run_access("mem_nsl", 1, 0, 1, 1, 0, 1, 16'h7FF5, 8'h07, 0, 8'h00, 0);
      run_access("rd_dly",  0, 0, 1, 1, 1, 0, 16'h4000, 8'h00, 5, 8'h5A, 1);
      run_access("rd_nodr", 0, 0, 1, 1, 1, 0, 16'h4000, 8'h00, 5, 8'h5A, 0);
      run_access("rd_tmo",  0, 0, 1, 1, 1, 0, 16'h4001, 8'h00, 20, 8'h33, 1);
      run_access("inta",    1, 1, 0, 0, 1, 0, 16'h0038, 8'h00, 0, 8'h11, 1);
      run_access("mr_io",   0, 0, 0, 1, 1, 0, 16'h0098, 8'h00, 0, 8'h22, 1);
      run_access("rd_wr",   0, 0, 1, 1, 1, 1, 16'h8000, 8'h44, 0, 8'h22, 1);

      for (int i = 0; i < 12; i++) begin
         bit   is_io, rd, sl;
         int   dly;
         is_io = 1'($urandom_range(0, 1));
         rd    = 1'($urandom_range(0, 1));
         sl    = ($urandom_range(0, 5) == 0);
         dly   = ($urandom_range(0, 4) == 0) ? 20 : int'($urandom_range(0, 6));
         if (is_io)
            run_access("rand_io", 1, 1, 0, 1, rd, !rd, 16'($urandom), 8'($urandom), dly,
                       8'($urandom), 1'($urandom_range(0, 1)));
         else
            run_access("rand_mem", sl, 0, 1, 1, rd, !rd, 16'($urandom), 8'($urandom), dly,
                       8'($urandom), 1'($urandom_range(0, 1)));
      end

      // Reset while a request is open; a strobe held through reset must not start a transfer.
      @(negedge clk);
      bus_ready   = 1'b0;
      slot_a      = 16'h1234;
      slot_d_in   = 8'h55;
      slot_iorq_n = 1'b0;
      slot_wr_n   = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         seen = bus_valid;
      end
      check("rst_mid.valid_seen", seen, 1);
      #2 reset = 1'b1;
      #1;
      m_tmo  = 1'b0;
      m_dout = 8'hFF;
      check_reset_outputs("rst_mid");
      @(negedge clk);
      reset = 1'b0;
      nv = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus_valid) nv++;
      end
      check("rst_mid.held_no_txn", nv, 0);
      idle_pins();
      repeat (4) @(negedge clk);
      run_access("post_rst", 1, 1, 0, 1, 0, 1, 16'h1234, 8'h55, 2, 8'h00, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
